dev_muldiv: RTL
===============

DEV_MULDIV -- requirements
Module: dev_muldiv

Interface
REQ-001 SHALL have parameter W, default pkg_reg::REG_WIDTH (64); operand and result width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  pkg_muldiv::op_t  operation: MULU, DIVQ (quotient), DIVR (remainder).
REQ-006 SHALL have port a  input  W  first operand (register file data_out0).
REQ-007 SHALL have port b  input  W  second operand (register file data_out1).
REQ-008 SHALL have port dst  input  pkg_reg address width  destination register index.
REQ-009 SHALL have port flush  input  1  synchronous abort of any operation in progress.
REQ-010 SHALL have port busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port wr_op  output  pkg_reg op type  REG_WRITE or no-op toward register file write port.
REQ-013 SHALL have port wr_addr  output  pkg_reg address width  write-back register index.
REQ-014 SHALL have port wr_data  output  W  write-back value.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 SHALL, in IDLE with start=1, latch op, a, b, dst, clear the cycle counter and go to RUN; start outside IDLE SHALL be ignored.
REQ-017 SHALL, for MULU, compute low W bits of unsigned a*b by shift-add, one bit per cycle, W cycles in RUN.
REQ-018 SHALL, for DIVQ/DIVR, compute unsigned a/b by restoring division, one bit per cycle, W cycles in RUN.
REQ-019 SHALL, when b==0 on a divide, skip RUN (IDLE -> DONE directly) with quotient all-ones and remainder = a.
REQ-020 SHALL leave RUN after exactly W cycles; done SHALL be high in the cycle after the W-th RUN cycle (W+1 cycles after the start edge; 1 cycle for divide-by-zero).
REQ-021 SHALL, in DONE, drive done=1, wr_addr=latched dst, wr_data=result, wr_op=REG_WRITE unless dst==0, in which case wr_op is the no-op and done still pulses.
REQ-022 SHALL drive wr_op as no-op, done=0, wr_data=0, wr_addr=0 outside DONE.
REQ-023 SHALL, on flush=1 in any state, return to IDLE next cycle without asserting done or REG_WRITE; flush has priority over start and completion.
REQ-024 SHALL accept a new start in the IDLE cycle directly following DONE (back-to-back throughput W+2 cycles).
REQ-025 SHALL use only internal latched operands; changes on a, b, dst, op after acceptance SHALL not affect the result.

Reset
REQ-026 SHALL on rst=1 asynchronously enter IDLE, clear counter, operand and result registers; busy=0, done=0, wr_op=no-op, wr_addr=0, wr_data=0.
REQ-027 SHALL, on reset mid-operation, discard the operation with no write-back after reset release.

Structure
REQ-028 SHALL take op_t (MULU, DIVQ, DIVR) and state_t from new package pkg_muldiv; register width, address width and REG_WRITE/no-op encoding from pkg_reg.
REQ-029 SHALL be a single module with no sub-modules; datapath shares one W-bit adder/subtractor between multiply and divide.

Verification
REQ-030 SHALL verify MULU a=7, b=6, dst=5 -> done exactly 65 cycles after start, wr_op=REG_WRITE, wr_addr=5, wr_data=42.
REQ-031 SHALL verify DIVQ a=100, b=7, dst=3 -> wr_data=14; DIVR same operands -> wr_data=2.
REQ-032 SHALL verify DIVQ a=9, b=0 -> done 1 cycle after start, wr_data=64'hFFFF_FFFF_FFFF_FFFF; DIVR -> wr_data=9.
REQ-033 SHALL verify MULU a=2^63, b=2, dst=0 -> done pulses, wr_op=no-op, wr_data=0 (low 64 bits).
REQ-034 SHALL verify start at cycle 10 of RUN ignored, and flush at cycle 20 -> no done, busy=0 next cycle, next start succeeds.
REQ-035 SHALL verify rst asserted mid-RUN -> outputs at reset values immediately, no write-back after release.

Source files
------------

// File: rtl/pkg_muldiv.sv
// Multiply/divide unit package: operation codes and FSM state encoding.
package pkg_muldiv;

    typedef enum logic [1:0] {
        MULU = 2'd0,   // low W bits of unsigned a*b
        DIVQ = 2'd1,   // unsigned quotient a/b
        DIVR = 2'd2    // unsigned remainder a%b
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pkg_reg.sv
// Register-file package: data width, address width and the write-port
// operation encoding shared by every unit that writes back to the
// register file.
package pkg_reg;

    localparam int REG_WIDTH  = 64;
    localparam int ADDR_WIDTH = 5;

    // Write-port command. Only REG_WRITE commits data; REG_NOP leaves the
    // register file untouched.
    typedef enum logic {
        REG_NOP   = 1'b0,
        REG_WRITE = 1'b1
    } reg_op_t;

endpackage

// File: rtl/dev_muldiv.sv
// dev_muldiv: iterative unsigned multiply / divide unit with register-file
// write-back. One result bit is produced per clock using a single shared
// W-bit adder/subtractor (shift-add multiply, restoring division).
//
// Ports
//   clk      sole clock, rising edge
//   rst      asynchronous active-high reset
//   start    request a new operation (sampled only in IDLE)
//   op       MULU / DIVQ / DIVR
//   a, b     operands, latched on acceptance
//   dst      destination register index, latched on acceptance
//   flush    synchronous abort; wins over start and completion
//   busy     high while in RUN or DONE
//   done     one-cycle completion pulse (the DONE state)
//   wr_op    REG_WRITE in DONE when dst != 0, otherwise REG_NOP
//   wr_addr  write-back index (0 outside DONE)
//   wr_data  write-back value (0 outside DONE)
//
// Handshake: start is a request with no ready; it is accepted exactly when
// start=1 in an IDLE cycle without flush. Any start seen while busy is
// dropped. A result is delivered for one cycle with done=1 and is not held.
module dev_muldiv
    import pkg_reg::*;
    import pkg_muldiv::*;
#(
    parameter int W = REG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  op_t                   op,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    input  logic [ADDR_WIDTH-1:0] dst,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output reg_op_t               wr_op,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [W-1:0]          wr_data
);

    localparam int CW = $clog2(W);

    state_t                state;
    op_t                   op_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [W-1:0]          acc;   // product accumulator / partial remainder
    logic [W-1:0]          ra;    // multiplicand (shifts left) / dividend->quotient
    logic [W-1:0]          rb;    // multiplier (shifts right) / divisor
    logic [CW-1:0]         cnt;

    logic                  is_mul;
    logic [W-1:0]          shift_rem;
    logic [W-1:0]          add_x;
    logic [W-1:0]          add_y;
    logic                  add_sub;
    logic [W:0]            add_out;
    logic                  div_ge;
    logic [W-1:0]          acc_nx;
    logic [W-1:0]          ra_nx;
    logic [W-1:0]          rb_nx;
    logic [W-1:0]          res_nx;

    assign is_mul    = (op_q == MULU);
    // Next dividend bit shifted into the partial remainder.
    assign shift_rem = {acc[W-2:0], ra[W-1]};

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = 1'b0;
        if (is_mul) begin
            add_x   = acc;
            add_y   = rb[0] ? ra : '0;
        end else begin
            add_x   = shift_rem;
            add_y   = rb;
            add_sub = 1'b1;
        end
    end

    // Shared adder; in subtract mode the carry-out means "no borrow".
    assign add_out = {1'b0, add_x} + {1'b0, add_y ^ {W{add_sub}}} + {{W{1'b0}}, add_sub};

    // The shifted remainder is really W+1 bits wide; if its top bit (old
    // acc MSB) is set it certainly exceeds the divisor, and the low W bits
    // of the W-bit difference are still the correct new remainder.
    assign div_ge = acc[W-1] | add_out[W];

    assign acc_nx = (is_mul || div_ge) ? add_out[W-1:0] : shift_rem;
    assign ra_nx  = is_mul ? {ra[W-2:0], 1'b0} : {ra[W-2:0], div_ge};
    assign rb_nx  = is_mul ? {1'b0, rb[W-1:1]} : rb;
    // MULU and DIVR both finish in acc; DIVQ finishes in ra.
    assign res_nx = (op_q == DIVQ) ? ra_nx : acc_nx;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= MULU;
            dst_q   <= '0;
            acc     <= '0;
            ra      <= '0;
            rb      <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            wr_op   <= REG_NOP;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            // Write-back outputs live for exactly one cycle.
            done    <= 1'b0;
            wr_op   <= REG_NOP;
            wr_addr <= '0;
            wr_data <= '0;
            if (flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            op_q  <= op;
                            dst_q <= dst;
                            cnt   <= '0;
                            acc   <= '0;
                            ra    <= a;
                            rb    <= b;
                            if (op != MULU && b == '0) begin
                                // Divide by zero: no iterations needed.
                                state   <= S_DONE;
                                done    <= 1'b1;
                                wr_addr <= dst;
                                wr_op   <= (dst != '0) ? REG_WRITE : REG_NOP;
                                wr_data <= (op == DIVQ) ? '1 : a;
                            end else begin
                                state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        acc <= acc_nx;
                        ra  <= ra_nx;
                        rb  <= rb_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(W - 1)) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            wr_addr <= dst_q;
                            wr_op   <= (dst_q != '0) ? REG_WRITE : REG_NOP;
                            wr_data <= res_nx;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
